// File: rtl/gray_decode_arbiter_pkg.sv
// Shared constants, types and helpers for the gray_decode_arbiter block.
package gray_arb_pkg;

  localparam int unsigned GRAY_W    = 4;
  localparam int unsigned GRAY_NREQ = 4;

  typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_e;

  // Ceiling log2 that never returns 0, so a 1-bit tag always exists.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = 32'(i + 1);
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/gray_decode_arbiter_if.sv
// Requester and result handshake bundle for gray_decode_arbiter.
interface gray_decode_arbiter_if #(
  parameter int unsigned W    = gray_arb_pkg::GRAY_W,
  parameter int unsigned NREQ = gray_arb_pkg::GRAY_NREQ
) ();
  localparam int unsigned IDW = gray_arb_pkg::clog2_min1(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_gray;
  logic [NREQ-1:0]   req_ready;
  logic              out_valid;
  logic [W-1:0]      out_bin;
  logic [IDW-1:0]    out_id;
  logic              out_ready;

  modport master (
    output req_valid, req_gray, out_ready,
    input  req_ready, out_valid, out_bin, out_id
  );

  modport slave (
    input  req_valid, req_gray, out_ready,
    output req_ready, out_valid, out_bin, out_id
  );

endinterface

// File: rtl/gray_decode_arbiter_gray2bin_w.sv
// Combinational Gray-to-binary decoder: each binary bit is the XOR of all Gray bits at or above it.
module gray2bin_w #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  always_comb begin
    bin = '0;
    for (int k = 0; k < int'(W); k++) begin
      bin[k] = ^(gray >> k);
    end
  end

endmodule

// File: rtl/gray_decode_arbiter.sv
// Round-robin arbiter sharing one Gray-to-binary decoder among NREQ requesters.
// Optional per-requester saturating grant counters: GRAY_DECODE_ARBITER_STATS_EN.
module gray_decode_arbiter
  import gray_arb_pkg::*;
#(
  parameter int unsigned W    = GRAY_W,
  parameter int unsigned NREQ = GRAY_NREQ
) (
  input  logic                 clk,
  input  logic                 rst_n,
  gray_decode_arbiter_if.slave bus
`ifdef GRAY_DECODE_ARBITER_STATS_EN
  ,
  output logic [NREQ*16-1:0]   grant_cnt
`endif
);

  localparam int unsigned IDW = clog2_min1(NREQ);

  out_state_e       state;
  logic [W-1:0]     out_bin_q;
  logic [IDW-1:0]   out_id_q;
  logic [IDW-1:0]   rr_ptr;

  logic             can_accept;
  logic             grant_any;
  logic             xfer;
  logic [IDW-1:0]   win;
  logic [NREQ-1:0]  ready;
  logic [W-1:0]     sel_gray;
  logic [W-1:0]     dec_bin;

  // Picker: the valid requester at the smallest circular distance past rr_ptr wins.
  always_comb begin
    int d;
    int best_d;
    grant_any = 1'b0;
    win       = '0;
    best_d    = int'(NREQ);
    d         = 0;
    for (int i = 0; i < int'(NREQ); i++) begin
      d = (i + int'(NREQ) - 1 - int'(rr_ptr)) % int'(NREQ);
      if (bus.req_valid[i] && (d < best_d)) begin
        best_d    = d;
        grant_any = 1'b1;
        win       = IDW'(i);
      end
    end
  end

  assign can_accept = (state == OUT_EMPTY) || bus.out_ready;
  assign xfer       = grant_any && can_accept && rst_n;

  always_comb begin
    ready    = '0;
    sel_gray = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      ready[i] = xfer && (win == IDW'(i));
      if (win == IDW'(i)) sel_gray = bus.req_gray[i*int'(W) +: W];
    end
  end

  gray2bin_w #(.W(W)) u_dec (
    .gray (sel_gray),
    .bin  (dec_bin)
  );

  // Output register and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= OUT_EMPTY;
      out_bin_q <= '0;
      out_id_q  <= '0;
      rr_ptr    <= IDW'(NREQ - 1);
    end else if (xfer) begin
      state     <= OUT_FULL;
      out_bin_q <= dec_bin;
      out_id_q  <= win;
      rr_ptr    <= win;
    end else if ((state == OUT_FULL) && bus.out_ready) begin
      state     <= OUT_EMPTY;
    end
  end

  assign bus.req_ready = ready;
  assign bus.out_valid = (state == OUT_FULL);
  assign bus.out_bin   = out_bin_q;
  assign bus.out_id    = out_id_q;

`ifdef GRAY_DECODE_ARBITER_STATS_EN
  logic [NREQ-1:0][15:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      for (int i = 0; i < int'(NREQ); i++) begin
        if (ready[i] && bus.req_valid[i] && (cnt[i] != 16'hFFFF)) cnt[i] <= cnt[i] + 16'd1;
      end
    end
  end

  assign grant_cnt = cnt;
`endif

endmodule

// File: doc/gray_decode_arbiter.md
Name: gray_decode_arbiter

Overview:
- Shares one W-bit Gray-to-binary decoder among NREQ requesters, e.g. FIFO pointer readers and encoder/counter taps.
- Round-robin arbitration with a valid/ready handshake on every requester port and on the single result port.
- Result is registered and tagged with the winning requester's ID. Sustained throughput is one conversion per cycle.

Parameters:
- W, 4: Gray/binary word width; legal range 2..32.
- NREQ, 4: number of requesters; legal range 2..16.
- IDW, $clog2(NREQ): width of the requester ID tag; derived, do not override.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low, synchronous deassert outside this block.
- req_valid  in  NREQ  per-requester request valid.
- req_gray  in  NREQ*W  packed Gray words; requester i occupies bits [i*W +: W]; MSB is bit W-1 of each slice.
- req_ready  out  NREQ  per-requester accept strobe; at most one bit high.
- out_valid  out  1  result register holds a valid word.
- out_bin  out  W  binary result.
- out_id  out  IDW  index of the requester that produced out_bin.
- out_ready  in  1  downstream accepts the result.

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid=0, out_bin=0, out_id=0, rr_ptr=NREQ-1. req_ready=0 while in reset.
- Decode rule:
  - bin[W-1] = gray[W-1].
  - bin[k] = bin[k+1] ^ gray[k] for k = W-2..0.
  - Purely combinational; no arithmetic widening.
- Output register (two states):
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
  - can_accept = !out_valid || out_ready, so a register drain and a new load can happen in the same cycle.
- Arbitration:
  - Search order is rr_ptr+1, rr_ptr+2, ... modulo NREQ, wrapping NREQ-1 -> 0.
  - The first requester with req_valid=1 wins.
  - req_ready[win] = can_accept. This is combinational (Mealy) from req_valid and out_ready. All other req_ready bits are 0.
- Transfer on req_valid[i] && req_ready[i]:
  - Next edge: out_bin <= decode(slice i), out_id <= i, out_valid <= 1, rr_ptr <= i.
  - Latency: exactly 1 cycle from accept to out_valid.
- Drain on out_valid && out_ready with no new transfer: next edge out_valid <= 0. out_bin and out_id hold their last values.
- Backpressure: while out_valid=1 and out_ready=0:
  - out_bin and out_id are held stable.
  - All req_ready bits are 0.
  - rr_ptr is frozen.
- Requester rules:
  - Once req_valid is asserted, it and its slice are held until req_ready is seen.
  - The block never requires this rule for correctness of the selected word. Deasserting valid before grant simply withdraws the request.
- No requester valid: no grant; rr_ptr unchanged.
- Fairness: a continuously requesting port waits at most NREQ-1 grants.
- Reset mid-operation: a pending result is discarded. The first post-reset grant goes to the lowest valid index.

Optional Feature:
- Macro: GRAY_DECODE_ARBITER_STATS_EN.
- Defined:
  - Adds output port grant_cnt, NREQ*16 bits, one 16-bit counter per requester.
  - Counter i increments on every transfer from requester i.
  - Counters saturate at 16'hFFFF; they do not wrap.
  - All counters reset to 0 on rst_n.
- Undefined: the port and counters do not exist. All other behaviour is identical.

Decomposition:
- Package gray_arb_pkg:
  - Default constants GRAY_W=4 and GRAY_NREQ=4.
  - Function clog2_min1 for the ID width; it returns at least 1.
  - Typedef of the output-register state enum {OUT_EMPTY, OUT_FULL}.
- Sub-module gray2bin_w: parameterised W, purely combinational decode. It is instantiated once, after the request mux, and is unit-testable alone.
- The round-robin picker stays inline.

Test Plan:
- Single request: requester 2 presents gray 4'b0110, out_ready=1 -> req_ready[2] the same cycle; next cycle out_valid=1, out_bin=4'b0100, out_id=2.
- All four requesters valid with gray 4'b1000, 4'b0001, 4'b1101, 4'b0110, out_ready=1 -> grants in order 0,1,2,3 on consecutive cycles. Results are 4'b1111, 4'b0001, 4'b1001, 4'b0100 with out_id 0..3, then the order repeats starting at 0.
- Backpressure: out_ready=0 for 5 cycles with requesters 1 and 3 valid -> out_bin and out_id stable and req_ready=0 throughout. On release, requester 3 is granted the same cycle if the last grant was 1.
- Simultaneous drain and load: out_valid=1 and out_ready=1 with requester 0 valid -> out_valid stays 1 and the new word appears with no bubble.
- Reset mid-operation: assert rst_n=0 while out_valid=1 -> out_valid drops immediately, asynchronously. After release, requesters 2 and 3 valid -> requester 2 is granted first.
- With GRAY_DECODE_ARBITER_STATS_EN: 70000 back-to-back grants to requester 1 -> grant_cnt slice 1 = 16'hFFFF and the other slices = 0.
